// File: rtl/ras.sv
// Return address stack: circular buffer of link targets with checkpoint restore.
// Top-of-stack and occupancy are driven purely from registered state.
module ras #(
    parameter int unsigned RAS_ENTRIES      = 8,
    parameter int unsigned RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES),
    parameter int unsigned RAS_TARGET_WIDTH = 31
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        link_valid,
    input  logic                        link_push,
    input  logic                        link_pop,
    input  logic [RAS_TARGET_WIDTH-1:0] link_push_target,
    output logic                        ret_valid,
    output logic [RAS_TARGET_WIDTH-1:0] ret_target,
    output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
    output logic [RAS_INDEX_WIDTH:0]    ras_count,
    input  logic                        restore_valid,
    input  logic [RAS_INDEX_WIDTH-1:0]  restore_index,
    input  logic [RAS_INDEX_WIDTH:0]    restore_count
);

    localparam logic [RAS_INDEX_WIDTH:0] MaxCount = (RAS_INDEX_WIDTH+1)'(RAS_ENTRIES);
    localparam logic [RAS_INDEX_WIDTH:0] OneCount = (RAS_INDEX_WIDTH+1)'(1);

    logic [RAS_TARGET_WIDTH-1:0] stack_q [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0]  index_q, index_d;
    logic [RAS_INDEX_WIDTH:0]    count_q, count_d;
    logic                        wr_en;
    logic [RAS_INDEX_WIDTH-1:0]  wr_addr;

    always_comb begin
        index_d = index_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = index_q;
        if (restore_valid) begin
            // Restore wins; any link action this cycle is dropped.
            index_d = restore_index;
            count_d = (restore_count > MaxCount) ? MaxCount : restore_count;
        end else if (link_valid) begin
            if (link_push && link_pop) begin
                // Return-then-call replaces the top in place.
                wr_en = 1'b1;
                if (count_q == '0) begin
                    count_d = OneCount;
                end
            end else if (link_push) begin
                wr_en   = 1'b1;
                wr_addr = index_q + 1'b1;
                index_d = index_q + 1'b1;
                if (count_q != MaxCount) begin
                    count_d = count_q + 1'b1;
                end
            end else if (link_pop && (count_q != '0)) begin
                index_d = index_q - 1'b1;
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            index_q <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(RAS_ENTRIES); i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            index_q <= index_d;
            count_q <= count_d;
            if (wr_en) begin
                stack_q[wr_addr] <= link_push_target;
            end
        end
    end

    assign ret_valid  = (count_q != '0);
    assign ret_target = stack_q[index_q];
    assign ras_index  = index_q;
    assign ras_count  = count_q;

endmodule

// File: tb/tb_ras.sv
// Randomized bench for ras: behavioural stack model compared every cycle,
// plus directed sequences with hand-computed expectations.
module tb_ras;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        link_valid, link_push, link_pop;
    logic [30:0] link_push_target;
    logic        ret_valid;
    logic [30:0] ret_target;
    logic [2:0]  ras_index;
    logic [3:0]  ras_count;
    logic        restore_valid;
    logic [2:0]  restore_index;
    logic [3:0]  restore_count;

    ras dut (
        .CLK              (clk),
        .RST              (rst),
        .link_valid       (link_valid),
        .link_push        (link_push),
        .link_pop         (link_pop),
        .link_push_target (link_push_target),
        .ret_valid        (ret_valid),
        .ret_target       (ret_target),
        .ras_index        (ras_index),
        .ras_count        (ras_count),
        .restore_valid    (restore_valid),
        .restore_index    (restore_index),
        .restore_count    (restore_count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit started = 1'b0;

    // Model: array of entries, a top position and an occupancy count.
    logic [30:0] m_stack [N];
    int          m_top = 0;
    int          m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m_stack[i] = '0;
            m_top = 0;
            m_cnt = 0;
        end else if (restore_valid) begin
            m_top = int'(restore_index);
            m_cnt = (int'(restore_count) > N) ? N : int'(restore_count);
        end else if (link_valid) begin
            if (link_push && link_pop) begin
                m_stack[m_top] = link_push_target;
                if (m_cnt == 0) m_cnt = 1;
            end else if (link_push) begin
                m_top = (m_top + 1) % N;
                m_stack[m_top] = link_push_target;
                if (m_cnt < N) m_cnt = m_cnt + 1;
            end else if (link_pop && m_cnt > 0) begin
                m_top = (m_top + N - 1) % N;
                m_cnt = m_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model ret_valid", {31'd0, ret_valid}, {31'd0, (m_cnt != 0)});
            chk("model ret_target", {1'b0, ret_target}, {1'b0, m_stack[m_top]});
            chk("model ras_index", {29'd0, ras_index}, 32'(m_top));
            chk("model ras_count", {28'd0, ras_count}, 32'(m_cnt));
        end
    end

    // Apply one cycle of inputs; returns #1 after the edge that consumed them.
    task automatic cyc(input logic r, input logic v, input logic pu, input logic po,
                       input logic [30:0] t, input logic rv, input logic [2:0] ri,
                       input logic [3:0] rc);
        rst = r; link_valid = v; link_push = pu; link_pop = po; link_push_target = t;
        restore_valid = rv; restore_index = ri; restore_count = rc;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [30:0] t);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, t, 1'b0, 3'd0, 4'd0);
    endtask

    task automatic pop();
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 31'h0, 1'b0, 3'd0, 4'd0);
    endtask

    task automatic pushpop(input logic [30:0] t);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, t, 1'b0, 3'd0, 4'd0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 31'h0, 1'b0, 3'd0, 4'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 31'h0, 1'b0, 3'd0, 4'd0);
        rst = 1'b0; link_valid = 1'b0; restore_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; link_valid = 1'b0; link_push = 1'b0; link_pop = 1'b0;
        link_push_target = '0; restore_valid = 1'b0; restore_index = '0; restore_count = '0;
        do_reset();
        started = 1'b1;
        chk("reset ret_valid", {31'd0, ret_valid}, 32'd0);
        chk("reset ret_target", {1'b0, ret_target}, 32'd0);
        chk("reset ras_index", {29'd0, ras_index}, 32'd0);
        chk("reset ras_count", {28'd0, ras_count}, 32'd0);

        push(31'h100); push(31'h200); push(31'h300);
        chk("order count", {28'd0, ras_count}, 32'd3);
        chk("order index", {29'd0, ras_index}, 32'd3);
        chk("order pop0", {1'b0, ret_target}, 32'h300); pop();
        chk("order pop1", {1'b0, ret_target}, 32'h200); pop();
        chk("order pop2", {1'b0, ret_target}, 32'h100); pop();
        chk("order empty", {28'd0, ras_count}, 32'd0);

        for (int i = 1; i <= 10; i++) push(31'(i));
        chk("wrap count", {28'd0, ras_count}, 32'd8);
        chk("wrap index", {29'd0, ras_index}, 32'd2);
        for (int i = 10; i >= 3; i--) begin
            chk("wrap pop", {1'b0, ret_target}, 32'(i));
            pop();
        end
        pop();
        chk("underflow count", {28'd0, ras_count}, 32'd0);
        chk("underflow index", {29'd0, ras_index}, 32'd2);
        chk("underflow valid", {31'd0, ret_valid}, 32'd0);

        do_reset();
        push(31'h100); push(31'h200);
        chk("pp before", {1'b0, ret_target}, 32'h200);
        pushpop(31'h555);
        chk("pp target", {1'b0, ret_target}, 32'h555);
        chk("pp count", {28'd0, ras_count}, 32'd2);
        chk("pp index", {29'd0, ras_index}, 32'd2);
        pop(); pop();
        pushpop(31'h666);
        chk("pp empty count", {28'd0, ras_count}, 32'd1);
        chk("pp empty target", {1'b0, ret_target}, 32'h666);

        do_reset();
        push(31'hA); push(31'hB);
        chk("ckpt index", {29'd0, ras_index}, 32'd2);
        chk("ckpt count", {28'd0, ras_count}, 32'd2);
        push(31'hC);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 31'hD, 1'b1, 3'd2, 4'd2);
        chk("restore index", {29'd0, ras_index}, 32'd2);
        chk("restore count", {28'd0, ras_count}, 32'd2);
        chk("restore target", {1'b0, ret_target}, 32'hB);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 31'h0, 1'b1, 3'd5, 4'd13);
        chk("restore clamp", {28'd0, ras_count}, 32'd8);

        cyc(1'b1, 1'b1, 1'b1, 1'b0, 31'h77, 1'b1, 3'd5, 4'd3);
        chk("midrst valid", {31'd0, ret_valid}, 32'd0);
        chk("midrst target", {1'b0, ret_target}, 32'd0);
        chk("midrst index", {29'd0, ras_index}, 32'd0);
        chk("midrst count", {28'd0, ras_count}, 32'd0);
        push(31'h42);
        chk("post rst index", {29'd0, ras_index}, 32'd1);
        chk("post rst count", {28'd0, ras_count}, 32'd1);
        chk("post rst target", {1'b0, ret_target}, 32'h42);

        for (int n = 0; n < 3000; n++) begin
            logic r, v, rv;
            logic [31:0] t;
            r  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 9) != 0);
            rv = ($urandom_range(0, 19) == 0);
            t  = $urandom;
            cyc(r, v, 1'($urandom), 1'($urandom), t[30:0], rv,
                3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        end
        rst = 1'b0; link_valid = 1'b0; restore_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ras.md
# ras

Return address stack for the fetch predictors. Stage 1 pushes link addresses on calls and pops them on returns; the stack's top feeds the return-target prediction. The branch-resolution backend restores stack state from a checkpoint after a misprediction. The stack is a circular buffer that overwrites its oldest entry on overflow. It is the read/restore counterpart of the checkpoint (`ras_index`, `ras_count`) that fetch attaches to each predicted branch.

## Interface
Parameters:
- `RAS_ENTRIES`, 8: stack depth; must be a power of two.
- `RAS_INDEX_WIDTH`, $clog2(RAS_ENTRIES): pointer width.
- `RAS_TARGET_WIDTH`, 31: stored target width, which is the PC without bit 0.

Ports:
- `CLK`, in, 1: the only clock.
- `RST`, in, 1: synchronous, active-high reset.
- `link_valid`, in, 1: a link action is requested this cycle.
- `link_push`, in, 1: the action includes a push (call).
- `link_pop`, in, 1: the action includes a pop (return).
- `link_push_target`, in, RAS_TARGET_WIDTH: address to push.
- `ret_valid`, out, 1: stack is non-empty (`ras_count != 0`).
- `ret_target`, out, RAS_TARGET_WIDTH: `stack[ras_index]`, the current top.
- `ras_index`, out, RAS_INDEX_WIDTH: top pointer, captured as the checkpoint.
- `ras_count`, out, RAS_INDEX_WIDTH+1: valid entry count, range 0..RAS_ENTRIES, captured as the checkpoint.
- `restore_valid`, in, 1: restore the stack from a checkpoint.
- `restore_index`, in, RAS_INDEX_WIDTH: checkpointed pointer.
- `restore_count`, in, RAS_INDEX_WIDTH+1: checkpointed count.

## Operation
State:
- `stack[RAS_ENTRIES]` of RAS_TARGET_WIDTH bits.
- `ras_index` register.
- `ras_count` register.

Actions when `link_valid` is high and `restore_valid` is low (writes and pointer math are modulo RAS_ENTRIES):
- **Push only:** write `stack[ras_index+1] <= link_push_target`; `ras_index <= ras_index+1`; `ras_count <= min(ras_count+1, RAS_ENTRIES)`. On a full stack the oldest entry is silently overwritten.
- **Pop only, `ras_count > 0`:** `ras_index <= ras_index-1`; `ras_count <= ras_count-1`. The popped entry's contents are not cleared.
- **Pop only, `ras_count == 0`:** no state change. `ret_valid` is 0 and `ret_target` shows a stale value.
- **Push and pop together (return-then-call, coroutine):** write `stack[ras_index] <= link_push_target`; `ras_index` is unchanged; `ras_count <= max(ras_count, 1)`.
- **Neither push nor pop:** no state change.

When `link_valid` is low, `link_push`, `link_pop` and `link_push_target` are ignored.

Restore:
- `restore_valid` has priority over any link action in the same cycle; that link action is dropped.
- `ras_index <= restore_index`; `ras_count <= min(restore_count, RAS_ENTRIES)`.
- Stack contents are not modified. Entries overwritten since the checkpoint stay corrupted; this is accepted predictor inaccuracy.

Reset:
- `RST` has priority over restore and link actions.
- `ras_index`, `ras_count` and all stack entries are set to 0, so `ret_valid` = 0 and `ret_target` = 0.

## Timing
- All state updates occur on the rising edge of `CLK`.
- `ret_valid`, `ret_target`, `ras_index` and `ras_count` are combinational from registered state only. There is no input-to-output combinational path.
- A pop's `ret_target` is the value presented in the same cycle the pop is requested (read-before-update). The next top is visible one cycle later.
- A push becomes visible as `ret_target` in the cycle after it is requested.
- A restore takes effect one cycle after `restore_valid`. A link request in the following cycle operates on the restored state.
- `RST` asserted mid-sequence clears all state at the next edge regardless of other inputs.
- Throughput is one link action per cycle with no stalls and no backpressure.

## Test plan
- **Reset:** hold `RST` for 2 cycles, then release. Require `ret_valid`=0, `ret_target`=0, `ras_index`=0, `ras_count`=0.
- **Push/pop order:** push 0x100, 0x200, 0x300 on consecutive cycles.
  - Require `ras_count`=3, `ras_index`=3, `ret_target`=0x300.
  - Pop 3 times. Require `ret_target` of 0x300, then 0x200, then 0x100 in the pop cycles, ending with `ras_count`=0.
- **Overflow wrap:** push 0x1..0xA (10 pushes).
  - Require `ras_count`=8 and `ras_index`=2.
  - 8 pops return 0xA down to 0x3.
  - A 9th pop leaves `ras_count`=0 and `ras_index` unchanged, with `ret_valid`=0.
- **Push+pop:** with the stack holding 0x100 then 0x200 (count 2), issue push+pop with 0x555.
  - Require `ret_target` 0x200 in that cycle.
  - Next cycle: `ret_target` 0x555, `ras_count`=2, index unchanged.
  - Repeat on an empty stack. Require `ras_count`=1.
- **Restore priority:**
  - Push 0xA and 0xB, then capture `ras_index`=2 and `ras_count`=2.
  - Push 0xC.
  - Assert `restore_valid` (index 2, count 2) together with a push of 0xD.
  - Next cycle require `ras_index`=2, `ras_count`=2, `ret_target`=0xB, and no effect from the push.
- **Reset mid-operation:**
  - Assert `RST` in the same cycle as a push and a restore.
  - Require all outputs 0 next cycle.
  - A following push of 0x42 gives `ras_index`=1, `ras_count`=1, `ret_target`=0x42.
